fme_sequenciador_fases: RTL

// Responder side of the FME interpolator control handshake. Decodes the current phase from the

---
 rtl/fme_sequenciador_fases.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fme_sequenciador_fases.sv
// Responder side of the FME interpolator control handshake: decodes the controller's phase,
// counts cycles per phase, returns the *_finalizada flags and flags sticky protocol errors.
//
// state (fase) | meaning
// INICIO   (0) | controller idle / reseto asserted
// ESCRITA  (1) | integer samples written into the buffer
// FASE1    (2) | first filtering pass
// FASE2    (3) | p1+p2+p3 group, counted as a single phase
// FASE3    (4) | third filtering pass
// POS      (5) | post-interpolation group
// INVALIDA (7) | control outputs match no legal phase
module fme_sequenciador_fases #(
   parameter int CONT_WIDTH = 4,
   parameter int N_ESCRITA  = 8,
   parameter int N_FASE1    = 8,
   parameter int N_FASE2    = 9,
   parameter int N_FASE3    = 9,
   parameter int N_POS      = 9
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  reseto,
   input  logic                  enable_buffer_int,
   input  logic                  modo_leitura,
   input  logic                  c0,
   input  logic                  c1,
   input  logic                  enable_filtros,
   input  logic                  done,
   output logic                  escrita_finalizada,
   output logic                  fase1_finalizada,
   output logic                  fase2p3_finalizada,
   output logic                  fase3_finalizada,
   output logic                  pos_interpolacao_finalizada,
   output logic [2:0]            fase,
   output logic [CONT_WIDTH-1:0] linha,
   output logic                  erro_protocolo
);

   typedef enum logic [2:0] {
      INICIO   = 3'd0,
      ESCRITA  = 3'd1,
      FASE1    = 3'd2,
      FASE2    = 3'd3,
      FASE3    = 3'd4,
      POS      = 3'd5,
      INVALIDA = 3'd7
   } fase_t;

   localparam int CW = CONT_WIDTH;
   localparam logic [CW:0]   N_ESC_W = (CW+1)'(N_ESCRITA);
   localparam logic [CW:0]   N_F1_W  = (CW+1)'(N_FASE1);
   localparam logic [CW:0]   N_F2_W  = (CW+1)'(N_FASE2);
   localparam logic [CW:0]   N_F3_W  = (CW+1)'(N_FASE3);
   localparam logic [CW:0]   N_POS_W = (CW+1)'(N_POS);
   localparam logic [CW:0]   UM_EXT  = (CW+1)'(1);
   localparam logic [CW-1:0] UM      = CW'(1);

   fase_t          fase_dec;
   fase_t          fase_ant;
   fase_t          fase_prox;
   logic [CW-1:0]  cont;
   logic [CW-1:0]  idx;
   logic [CW:0]    idx_ext;
   logic [CW:0]    n_fase;
   logic           ativa;
   logic           no_fim;
   logic           overrun;
   logic           mov_legal;

   // Priority decode of the controller outputs; reseto dominates, then done.
   always_comb begin
      fase_dec = INVALIDA;
      if (reseto) begin
         fase_dec = INICIO;
      end else if (done) begin
         fase_dec = enable_filtros ? INVALIDA : POS;
      end else if (!enable_filtros) begin
         fase_dec = (enable_buffer_int && !modo_leitura) ? ESCRITA : INVALIDA;
      end else begin
         case ({c1, c0})
            2'b00:   fase_dec = FASE1;
            2'b10:   fase_dec = FASE2;
            2'b11:   fase_dec = FASE3;
            default: fase_dec = INVALIDA;
         endcase
      end
   end

   assign fase = fase_dec;

   always_comb begin
      n_fase = '0;
      case (fase_dec)
         ESCRITA: n_fase = N_ESC_W;
         FASE1:   n_fase = N_F1_W;
         FASE2:   n_fase = N_F2_W;
         FASE3:   n_fase = N_F3_W;
         POS:     n_fase = N_POS_W;
         default: n_fase = '0;
      endcase
   end

   always_comb begin
      fase_prox = INVALIDA;
      case (fase_ant)
         INICIO:  fase_prox = ESCRITA;
         ESCRITA: fase_prox = FASE1;
         FASE1:   fase_prox = FASE2;
         FASE2:   fase_prox = FASE3;
         FASE3:   fase_prox = POS;
         POS:     fase_prox = INICIO;
         default: fase_prox = INVALIDA;
      endcase
   end

   assign ativa     = (fase_dec != INICIO) && (fase_dec != INVALIDA);
   assign idx       = (fase_dec != fase_ant) ? '0 : cont;
   assign idx_ext   = {1'b0, idx};
   assign linha     = ativa ? idx : '0;
   assign no_fim    = ativa && (idx_ext == (n_fase - UM_EXT));
   assign overrun   = ativa && (idx_ext >= n_fase);
   assign mov_legal = (fase_dec == fase_ant) || (fase_dec == fase_prox);

   // Flags are zero-latency so the controller can leave the phase on the same edge.
   assign escrita_finalizada          = !reset && no_fim && (fase_dec == ESCRITA);
   assign fase1_finalizada            = !reset && no_fim && (fase_dec == FASE1);
   assign fase2p3_finalizada          = !reset && no_fim && (fase_dec == FASE2);
   assign fase3_finalizada            = !reset && no_fim && (fase_dec == FASE3);
   assign pos_interpolacao_finalizada = !reset && no_fim && (fase_dec == POS);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fase_ant       <= INICIO;
         cont           <= '0;
         erro_protocolo <= 1'b0;
      end else begin
         fase_ant <= fase_dec;
         cont     <= (&idx) ? idx : idx + UM;
         if (!mov_legal || (fase_dec == INVALIDA) || overrun)
            erro_protocolo <= 1'b1;
      end
   end

endmodule
